idu_pipe: RTL and testbench
===========================

Name: idu_pipe

Overview:
Parametrised decode stage for the NPC core. It sits between the fetch unit and the execute/register-file stage, with valid/ready handshakes on both sides. A DEPTH-entry instruction buffer absorbs fetch bursts. Each instruction is decoded into a registered bundle carrying register addresses, sign-extended immediate, class flags and trap/illegal indications. The register-file size is configurable for RV32I or RV32E.

Parameters:
XLEN, 32, datapath/immediate width (must be 32)
NREG, 32, architectural register count: 32 for RV32I, 16 for RV32E
DEPTH, 4, instruction buffer entries; power of two, minimum 2

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
flush  in  1  discard buffered and output-staged instructions
in_valid  in  1  fetch offers instruction
in_ready  out  1  buffer can accept
in_inst  in  32  instruction word
in_pc  in  XLEN  PC of instruction
out_valid  out  1  decoded bundle valid
out_ready  in  1  downstream accepts bundle
out_pc  out  XLEN  PC of decoded instruction
out_opcode  out  7  inst[6:0]
out_funct3  out  3  inst[14:12]
out_rd  out  5  destination register; 0 for branch/store
out_rs1  out  5  source 1; 0 for LUI/AUIPC/JAL
out_rs2  out  5  source 2; valid only for branch/store/OP, else 0
out_imm  out  XLEN  sign-extended immediate
out_imm_type  out  3  0=none 1=I 2=S 3=B 4=U 5=J
out_csr  out  12  inst[31:20] for SYSTEM, else 0
out_is_load  out  1  opcode 0000011
out_is_store  out  1  opcode 0100011
out_is_ebreak  out  1  inst == 0x00100073
out_is_ecall  out  1  inst == 0x00000073
out_irq_no  out  32  11 when ecall, else 0
out_illegal  out  1  illegal instruction

Behaviour:
- Reset (rst=0 at clk edge): buffer empty, out_valid=0, every out_* field 0; in_ready=0 during reset, 1 on the first cycle after.
- Buffer: circular FIFO with read/write pointers and occupancy count; push when in_valid && in_ready; in_ready = !full. in_ready depends only on occupancy, with no combinational path from out_ready.
- Output register: loads the decode of the FIFO head when FIFO non-empty and (!out_valid || out_ready). Cleared to out_valid=0 when it is consumed and the FIFO is empty.
- Latency: an instruction pushed at edge N appears with out_valid=1 after edge N+1 if FIFO and output are empty. No bypass from input to output.
- Throughput: one instruction per cycle sustained when out_ready=1. A simultaneous push and pop keep the count unchanged; pointers wrap modulo DEPTH.
- Backpressure: with out_ready=0 the bundle and all fields hold stable. Capacity is DEPTH+1 instructions (FIFO plus output register).
- Flush: synchronous, at next edge. Empties FIFO, clears out_valid, and ignores any same-cycle push. Flush has priority over push and pop. Reset has priority over flush.
- Immediates: I = sext(inst[31:20]); S = sext({inst[31:25],inst[11:7]}); B = sext({inst[31],inst[7],inst[30:25],inst[11:8],0}); U = {inst[31:12],12'b0}; J = sext({inst[31],inst[19:12],inst[20],inst[30:21],0}). imm_type is selected by opcode (JALR/LOAD/OP-IMM/SYSTEM = I).
- Illegal is asserted for any of:
  - opcode not in {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, SYSTEM};
  - SLLI/SRLI/SRAI with inst[25]=1;
  - NREG=16 and bit 4 set in any used rd/rs1/rs2 field.
- The bundle is still presented when illegal is asserted; downstream raises the trap.
- ebreak/ecall flags are registered with the bundle, never combinational from in_inst.

Test Plan:
- Reset, then push 0x00500093 (addi x1,x0,5) at pc 0x80000000 -> next cycle out_valid=1, rd=1, rs1=0, imm=5, imm_type=1, illegal=0.
- Push 0xFE20AE23 (sw x2,-4(x1)) -> rs1=1, rs2=2, rd=0, imm=0xFFFFFFFC, imm_type=2, is_store=1.
- Push 0x00000073, then 0x00100073 -> first bundle is_ecall=1, irq_no=11; second is_ebreak=1, irq_no=0. Push 0x02009093 (slli shamt[5]=1) -> illegal=1.
- DEPTH=4, out_ready=0, in_valid held high with distinct PCs -> exactly 5 accepted, then in_ready=0. Raise out_ready -> 5 bundles in order on consecutive cycles, in_ready back to 1 one cycle after the first pop.
- NREG=16: push add x17,x1,x2 (0x002088B3) -> illegal=1; same instruction with NREG=32 -> illegal=0.
- Fill to 3 entries, assert flush together with in_valid -> next cycle out_valid=0, buffer empty, pushed word dropped; rst=0 mid-stream -> all outputs 0 after that edge.

Source files
------------

// File: rtl/idu_pipe.sv
// idu_pipe: decode stage between fetch and execute.
// Fetched words are queued in a small circular buffer; the head entry is
// decoded combinationally and captured into a registered output bundle.
// A bundle is always presented, even when flagged illegal, so that the
// downstream stage owns trap handling.

module idu_pipe #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_imm_type,
    output logic [11:0]     out_csr,
    output logic            out_is_load,
    output logic            out_is_store,
    output logic            out_is_ebreak,
    output logic            out_is_ecall,
    output logic [31:0]     out_irq_no,
    output logic            out_illegal
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic RV32E = (NREG == 16);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_J    = 3'd5;

    // Buffer storage and bookkeeping
    logic [31:0]     inst_mem_q [DEPTH];
    logic [XLEN-1:0] pc_mem_q   [DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic            full;
    logic            empty;
    logic            push;
    logic            load;

    // Decode of the buffer head
    logic [31:0]     head_inst;
    logic [4:0]      dec_rd;
    logic [4:0]      dec_rs1;
    logic [4:0]      dec_rs2;
    logic [2:0]      dec_imm_type;
    logic [XLEN-1:0] dec_imm;
    logic [11:0]     dec_csr;
    logic            dec_known;
    logic            dec_shift_bad;
    logic            dec_reg_bad;
    logic            dec_illegal;
    logic            dec_ecall;
    logic            dec_ebreak;

    // Output bundle registers
    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [6:0]      opcode_q;
    logic [2:0]      funct3_q;
    logic [4:0]      rd_q;
    logic [4:0]      rs1_q;
    logic [4:0]      rs2_q;
    logic [XLEN-1:0] imm_q;
    logic [2:0]      imm_type_q;
    logic [11:0]     csr_q;
    logic            is_load_q;
    logic            is_store_q;
    logic            is_ebreak_q;
    logic            is_ecall_q;
    logic            illegal_q;

    // Handshake and pointer next-state; in_ready looks only at occupancy
    always_comb begin
        full     = (count_q == DEPTH_C);
        empty    = (count_q == '0);
        in_ready = rst && !full;
        push     = in_valid && in_ready;
        load     = !empty && (!valid_q || out_ready);
        wptr_d   = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d   = load ? rptr_q + AW'(1) : rptr_q;
        case ({push, load})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; flush drops everything buffered
    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Buffer write port; a push in a flush cycle is discarded
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            inst_mem_q[wptr_q] <= in_inst;
            pc_mem_q[wptr_q]   <= in_pc;
        end
    end

    assign head_inst = inst_mem_q[rptr_q];

    // Field extraction, immediate formation and legality of the head word
    always_comb begin
        dec_rd        = head_inst[11:7];
        dec_rs1       = head_inst[19:15];
        dec_rs2       = '0;
        dec_imm_type  = IMM_NONE;
        dec_csr       = '0;
        dec_known     = 1'b1;
        dec_shift_bad = 1'b0;
        case (head_inst[6:0])
            OPC_LUI, OPC_AUIPC: begin
                dec_rs1      = '0;
                dec_imm_type = IMM_U;
            end
            OPC_JAL: begin
                dec_rs1      = '0;
                dec_imm_type = IMM_J;
            end
            OPC_JALR, OPC_LOAD: begin
                dec_imm_type = IMM_I;
            end
            OPC_BRANCH: begin
                dec_rd       = '0;
                dec_rs2      = head_inst[24:20];
                dec_imm_type = IMM_B;
            end
            OPC_STORE: begin
                dec_rd       = '0;
                dec_rs2      = head_inst[24:20];
                dec_imm_type = IMM_S;
            end
            OPC_OPIMM: begin
                dec_imm_type  = IMM_I;
                dec_shift_bad = (head_inst[13:12] == 2'b01) && head_inst[25];
            end
            OPC_OP: begin
                dec_rs2 = head_inst[24:20];
            end
            OPC_SYSTEM: begin
                dec_imm_type = IMM_I;
                dec_csr      = head_inst[31:20];
            end
            default: begin
                dec_known = 1'b0;
            end
        endcase

        case (dec_imm_type)
            IMM_I:   dec_imm = {{(XLEN-12){head_inst[31]}}, head_inst[31:20]};
            IMM_S:   dec_imm = {{(XLEN-12){head_inst[31]}}, head_inst[31:25], head_inst[11:7]};
            IMM_B:   dec_imm = {{(XLEN-12){head_inst[31]}}, head_inst[7], head_inst[30:25],
                                head_inst[11:8], 1'b0};
            IMM_U:   dec_imm = {head_inst[31:12], {(XLEN-20){1'b0}}};
            IMM_J:   dec_imm = {{(XLEN-20){head_inst[31]}}, head_inst[19:12], head_inst[20],
                                head_inst[30:21], 1'b0};
            default: dec_imm = '0;
        endcase

        // Unused register fields are already zeroed, so OR-ing them is safe
        dec_reg_bad = RV32E && (dec_rd[4] || dec_rs1[4] || dec_rs2[4]);
        dec_illegal = !dec_known || dec_shift_bad || dec_reg_bad;
        dec_ecall   = (head_inst == 32'h0000_0073);
        dec_ebreak  = (head_inst == 32'h0010_0073);
    end

    // Output bundle: capture head on load, drop valid once consumed and dry
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            opcode_q    <= '0;
            funct3_q    <= '0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            imm_q       <= '0;
            imm_type_q  <= '0;
            csr_q       <= '0;
            is_load_q   <= 1'b0;
            is_store_q  <= 1'b0;
            is_ebreak_q <= 1'b0;
            is_ecall_q  <= 1'b0;
            illegal_q   <= 1'b0;
        end else if (load) begin
            valid_q     <= 1'b1;
            pc_q        <= pc_mem_q[rptr_q];
            opcode_q    <= head_inst[6:0];
            funct3_q    <= head_inst[14:12];
            rd_q        <= dec_rd;
            rs1_q       <= dec_rs1;
            rs2_q       <= dec_rs2;
            imm_q       <= dec_imm;
            imm_type_q  <= dec_imm_type;
            csr_q       <= dec_csr;
            is_load_q   <= (head_inst[6:0] == OPC_LOAD);
            is_store_q  <= (head_inst[6:0] == OPC_STORE);
            is_ebreak_q <= dec_ebreak;
            is_ecall_q  <= dec_ecall;
            illegal_q   <= dec_illegal;
        end else if (out_ready) begin
            valid_q     <= 1'b0;
        end
    end

    assign out_valid     = valid_q;
    assign out_pc        = pc_q;
    assign out_opcode    = opcode_q;
    assign out_funct3    = funct3_q;
    assign out_rd        = rd_q;
    assign out_rs1       = rs1_q;
    assign out_rs2       = rs2_q;
    assign out_imm       = imm_q;
    assign out_imm_type  = imm_type_q;
    assign out_csr       = csr_q;
    assign out_is_load   = is_load_q;
    assign out_is_store  = is_store_q;
    assign out_is_ebreak = is_ebreak_q;
    assign out_is_ecall  = is_ecall_q;
    assign out_irq_no    = is_ecall_q ? 32'd11 : 32'd0;
    assign out_illegal   = illegal_q;

endmodule

// File: tb/tb_idu_pipe.sv
// Bench for idu_pipe: an RV32I and an RV32E instance share one stimulus
// stream and are both checked every cycle against a queue-based model.

module tb_idu_pipe;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [2:0]  imm_type;
        logic [11:0] csr;
        logic        is_load;
        logic        is_store;
        logic        ebreak;
        logic        ecall;
        logic [31:0] irq;
        logic        illegal;
    } bund_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_inst, in_pc;

    logic        rdy_a, vld_a, ld_a, st_a, eb_a, ec_a, ill_a;
    logic [31:0] pc_a, imm_a, irq_a;
    logic [6:0]  opc_a;
    logic [2:0]  f3_a, it_a;
    logic [4:0]  rd_a, rs1_a, rs2_a;
    logic [11:0] csr_a;

    logic        rdy_b, vld_b, ld_b, st_b, eb_b, ec_b, ill_b;
    logic [31:0] pc_b, imm_b, irq_b;
    logic [6:0]  opc_b;
    logic [2:0]  f3_b, it_b;
    logic [4:0]  rd_b, rs1_b, rs2_b;
    logic [11:0] csr_b;

    idu_pipe #(.XLEN(32), .NREG(32), .DEPTH(DEPTH)) dut_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_a),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(vld_a), .out_ready(out_ready),
        .out_pc(pc_a), .out_opcode(opc_a), .out_funct3(f3_a), .out_rd(rd_a),
        .out_rs1(rs1_a), .out_rs2(rs2_a), .out_imm(imm_a), .out_imm_type(it_a),
        .out_csr(csr_a), .out_is_load(ld_a), .out_is_store(st_a), .out_is_ebreak(eb_a),
        .out_is_ecall(ec_a), .out_irq_no(irq_a), .out_illegal(ill_a)
    );

    idu_pipe #(.XLEN(32), .NREG(16), .DEPTH(DEPTH)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_b),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(vld_b), .out_ready(out_ready),
        .out_pc(pc_b), .out_opcode(opc_b), .out_funct3(f3_b), .out_rd(rd_b),
        .out_rs1(rs1_b), .out_rs2(rs2_b), .out_imm(imm_b), .out_imm_type(it_b),
        .out_csr(csr_b), .out_is_load(ld_b), .out_is_store(st_b), .out_is_ebreak(eb_b),
        .out_is_ecall(ec_b), .out_irq_no(irq_b), .out_illegal(ill_b)
    );

    bund_t act_a, act_b;

    always_comb begin
        act_a.pc = pc_a;   act_a.opcode = opc_a; act_a.funct3 = f3_a; act_a.rd = rd_a;
        act_a.rs1 = rs1_a; act_a.rs2 = rs2_a;    act_a.imm = imm_a;   act_a.imm_type = it_a;
        act_a.csr = csr_a; act_a.is_load = ld_a; act_a.is_store = st_a;
        act_a.ebreak = eb_a; act_a.ecall = ec_a; act_a.irq = irq_a;   act_a.illegal = ill_a;
        act_b.pc = pc_b;   act_b.opcode = opc_b; act_b.funct3 = f3_b; act_b.rd = rd_b;
        act_b.rs1 = rs1_b; act_b.rs2 = rs2_b;    act_b.imm = imm_b;   act_b.imm_type = it_b;
        act_b.csr = csr_b; act_b.is_load = ld_b; act_b.is_store = st_b;
        act_b.ebreak = eb_b; act_b.ecall = ec_b; act_b.irq = irq_b;   act_b.illegal = ill_b;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bund_t zero_b();
        bund_t d;
        d.pc = '0; d.opcode = '0; d.funct3 = '0; d.rd = '0; d.rs1 = '0; d.rs2 = '0;
        d.imm = '0; d.imm_type = '0; d.csr = '0; d.is_load = 1'b0; d.is_store = 1'b0;
        d.ebreak = 1'b0; d.ecall = 1'b0; d.irq = '0; d.illegal = 1'b0;
        return d;
    endfunction

    // Reference decode written from the instruction-format rules
    function automatic bund_t model_dec(input logic [31:0] i, input int nreg);
        bund_t d;
        int    imm;
        int    kind;
        bit    use_rd, use_rs1, use_rs2, known, shift_bad;
        d = zero_b();
        d.opcode = i[6:0];
        d.funct3 = i[14:12];
        known = 1; use_rd = 1; use_rs1 = 1; use_rs2 = 0; kind = 0;
        case (i[6:0])
            7'h37, 7'h17:        begin use_rs1 = 0; kind = 4; end
            7'h6F:               begin use_rs1 = 0; kind = 5; end
            7'h67, 7'h03, 7'h73: kind = 1;
            7'h13:               kind = 1;
            7'h63:               begin use_rd = 0; use_rs2 = 1; kind = 3; end
            7'h23:               begin use_rd = 0; use_rs2 = 1; kind = 2; end
            7'h33:               use_rs2 = 1;
            default:             known = 0;
        endcase
        d.rd  = use_rd  ? i[11:7]  : 5'd0;
        d.rs1 = use_rs1 ? i[19:15] : 5'd0;
        d.rs2 = use_rs2 ? i[24:20] : 5'd0;
        case (kind)
            1:       imm = int'(i[31:20]) - (i[31] ? 4096 : 0);
            2:       imm = int'({i[31:25], i[11:7]}) - (i[31] ? 4096 : 0);
            3:       imm = int'({i[31], i[7], i[30:25], i[11:8]}) * 2 - (i[31] ? 8192 : 0);
            4:       imm = int'(i[31:12]) << 12;
            5:       imm = int'({i[31], i[19:12], i[20], i[30:21]}) * 2 - (i[31] ? 2097152 : 0);
            default: imm = 0;
        endcase
        d.imm      = imm;
        d.imm_type = 3'(kind);
        d.csr      = (i[6:0] == 7'h73) ? i[31:20] : 12'd0;
        d.is_load  = (i[6:0] == 7'h03);
        d.is_store = (i[6:0] == 7'h23);
        d.ecall    = (i == 32'h0000_0073);
        d.ebreak   = (i == 32'h0010_0073);
        d.irq      = d.ecall ? 32'd11 : 32'd0;
        shift_bad  = (i[6:0] == 7'h13) && (i[14:12] == 3'd1 || i[14:12] == 3'd5) && i[25];
        d.illegal  = !known || shift_bad ||
                     (nreg == 16 && ((d.rd | d.rs1 | d.rs2) & 5'h10) != 5'h0);
        return d;
    endfunction

    task automatic chk_bundle(input string t, input bund_t a, input bund_t e, input bit with_imm);
        chk({t, ".pc"},       a.pc,                e.pc);
        chk({t, ".opcode"},   32'(a.opcode),       32'(e.opcode));
        chk({t, ".funct3"},   32'(a.funct3),       32'(e.funct3));
        chk({t, ".rd"},       32'(a.rd),           32'(e.rd));
        chk({t, ".rs1"},      32'(a.rs1),          32'(e.rs1));
        chk({t, ".rs2"},      32'(a.rs2),          32'(e.rs2));
        if (with_imm) chk({t, ".imm"}, a.imm, e.imm);
        chk({t, ".imm_type"}, 32'(a.imm_type),     32'(e.imm_type));
        chk({t, ".csr"},      32'(a.csr),          32'(e.csr));
        chk({t, ".is_load"},  32'(a.is_load),      32'(e.is_load));
        chk({t, ".is_store"}, 32'(a.is_store),     32'(e.is_store));
        chk({t, ".ebreak"},   32'(a.ebreak),       32'(e.ebreak));
        chk({t, ".ecall"},    32'(a.ecall),        32'(e.ecall));
        chk({t, ".irq_no"},   a.irq,               e.irq);
        chk({t, ".illegal"},  32'(a.illegal),      32'(e.illegal));
    endtask

    // Model state: queued entries, output slot, and a "fields cleared" flag
    ent_t mq[$];
    bit   m_ov   = 0;
    bit   m_zero = 0;
    bit   m_live = 0;
    ent_t m_out;

    task automatic cmp_side(input string t, input bund_t a, input logic vld, input logic rdy,
                            input int nreg);
        bund_t e;
        chk({t, ".in_ready"},  32'(rdy), 32'(rst && mq.size() < DEPTH));
        chk({t, ".out_valid"}, 32'(vld), 32'(m_ov));
        if (m_ov) begin
            e = model_dec(m_out.inst, nreg);
            e.pc = m_out.pc;
            chk_bundle(t, a, e, e.imm_type != 3'd0);
        end else if (m_zero) begin
            chk_bundle(t, a, zero_b(), 1'b1);
        end
    endtask

    // Model update at each edge from the inputs held across it, then compare
    initial begin
        logic r, f, v, ordy;
        logic [31:0] ii, pp;
        bit acc;
        forever begin
            @(posedge clk);
            r = rst; f = flush; v = in_valid; ordy = out_ready; ii = in_inst; pp = in_pc;
            if (!r) begin
                mq.delete(); m_ov = 0; m_zero = 1; m_live = 1;
            end else if (m_live) begin
                if (f) begin
                    mq.delete(); m_ov = 0; m_zero = 1;
                end else begin
                    acc = v && (mq.size() < DEPTH);
                    if (mq.size() > 0 && (!m_ov || ordy)) begin
                        m_out = mq.pop_front(); m_ov = 1; m_zero = 0;
                    end else if (ordy) begin
                        m_ov = 0;
                    end
                    if (acc) mq.push_back('{inst: ii, pc: pp});
                end
            end
            #1;
            if (m_live) begin
                cmp_side("rv32i", act_a, vld_a, rdy_a, 32);
                cmp_side("rv32e", act_b, vld_b, rdy_b, 16);
            end
        end
    end

    logic [6:0] legal_ops [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63,
                                   7'h03, 7'h23, 7'h13, 7'h33, 7'h73};

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        int sel;
        w = $urandom;
        sel = $urandom_range(0, 19);
        if (sel == 0)       w = 32'h0000_0073;
        else if (sel == 1)  w = 32'h0010_0073;
        else if (sel < 17)  w[6:0] = legal_ops[$urandom_range(0, 9)];
        return w;
    endfunction

    task automatic push_one(input logic [31:0] w, input logic [31:0] p);
        @(negedge clk);
        in_valid = 1'b1; in_inst = w; in_pc = p;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string name);
        int n;
        n = 0;
        while (!vld_a && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({name, ".arrival"}, 32'(vld_a), 32'd1);
    endtask

    initial begin
        bit r;
        int accepted;
        bund_t pin;
        logic [31:0] base;

        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_inst = '0; in_pc = '0;

        // Model sanity against hand-derived values
        pin = model_dec(32'h0050_0093, 32); chk("pin.addi_imm", pin.imm, 32'd5);
        pin = model_dec(32'hFE20_AE23, 32); chk("pin.sw_imm", pin.imm, 32'hFFFF_FFFC);
        pin = model_dec(32'hFE00_0EE3, 32); chk("pin.beq_imm", pin.imm, 32'hFFFF_FFFC);
        pin = model_dec(32'h0020_88B3, 16); chk("pin.rv32e_x17", 32'(pin.illegal), 32'd1);

        repeat (3) @(negedge clk);
        chk("reset.in_ready", 32'(rdy_a), 32'd0);
        chk("reset.out_valid", 32'(vld_a), 32'd0);
        chk("reset.out_pc", pc_a, 32'd0);
        chk("reset.out_imm", imm_a, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_reset.in_ready", 32'(rdy_a), 32'd1);

        push_one(32'h0050_0093, 32'h8000_0000);
        chk("addi.latency_not_yet", 32'(vld_a), 32'd0);
        @(negedge clk);
        chk("addi.valid", 32'(vld_a), 32'd1);
        chk("addi.pc", pc_a, 32'h8000_0000);
        chk("addi.rd", 32'(rd_a), 32'd1);
        chk("addi.rs1", 32'(rs1_a), 32'd0);
        chk("addi.imm", imm_a, 32'd5);
        chk("addi.imm_type", 32'(it_a), 32'd1);
        chk("addi.illegal", 32'(ill_a), 32'd0);

        push_one(32'hFE20_AE23, 32'h8000_0004);
        wait_out("sw");
        chk("sw.rs1", 32'(rs1_a), 32'd1);
        chk("sw.rs2", 32'(rs2_a), 32'd2);
        chk("sw.rd", 32'(rd_a), 32'd0);
        chk("sw.imm", imm_a, 32'hFFFF_FFFC);
        chk("sw.imm_type", 32'(it_a), 32'd2);
        chk("sw.is_store", 32'(st_a), 32'd1);

        push_one(32'h0000_0073, 32'h8000_0008);
        wait_out("ecall");
        chk("ecall.flag", 32'(ec_a), 32'd1);
        chk("ecall.irq", irq_a, 32'd11);
        push_one(32'h0010_0073, 32'h8000_000C);
        wait_out("ebreak");
        chk("ebreak.flag", 32'(eb_a), 32'd1);
        chk("ebreak.irq", irq_a, 32'd0);

        push_one(32'h0200_9093, 32'h8000_0010);
        wait_out("slli");
        chk("slli.illegal", 32'(ill_a), 32'd1);

        push_one(32'h0020_88B3, 32'h8000_0014);
        wait_out("add17");
        chk("add17.rv32i_illegal", 32'(ill_a), 32'd0);
        chk("add17.rv32e_illegal", 32'(ill_b), 32'd1);
        chk("add17.rd", 32'(rd_a), 32'd17);

        // Capacity: DEPTH in the buffer plus one in the output register
        @(negedge clk);
        base = 32'h0000_1000;
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = base; in_inst = rand_inst();
        accepted = 0;
        repeat (9) begin
            r = rdy_a;
            @(negedge clk);
            if (r) begin
                accepted++;
                in_pc = base + 32'(accepted * 4);
                in_inst = rand_inst();
            end
        end
        in_valid = 1'b0;
        chk("full.accepted", 32'(accepted), 32'd5);
        chk("full.in_ready", 32'(rdy_a), 32'd0);
        chk("full.head_pc", pc_a, base);
        out_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            chk("drain.valid", 32'(vld_a), 32'd1);
            chk("drain.pc", pc_a, base + 32'(k * 4));
            if (k == 1) chk("drain.in_ready", 32'(rdy_a), 32'd1);
        end
        @(negedge clk);
        chk("drain.empty", 32'(vld_a), 32'd0);

        // Flush with a simultaneous push
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_inst = rand_inst(); in_pc = 32'h2000 + 32'(k * 4);
            @(negedge clk);
        end
        flush = 1'b1; in_inst = 32'h0050_0093; in_pc = 32'h2FFC;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush.out_valid", 32'(vld_a), 32'd0);
        chk("flush.in_ready", 32'(rdy_a), 32'd1);
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("flush.dropped", 32'(vld_a), 32'd0);
        end

        // Randomised traffic with occasional flush and reset
        repeat (3000) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            rst       = ($urandom_range(0, 299) != 0);
            in_inst   = rand_inst();
            in_pc     = $urandom;
        end
        @(negedge clk);
        rst = 1'b1; flush = 1'b0;

        // Reset in the middle of traffic
        out_ready = 1'b0; in_valid = 1'b1;
        repeat (3) begin
            in_inst = rand_inst(); in_pc = $urandom;
            @(negedge clk);
        end
        rst = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("midrst.in_ready", 32'(rdy_a), 32'd0);
        chk("midrst.out_valid", 32'(vld_a), 32'd0);
        chk("midrst.out_pc", pc_a, 32'd0);
        chk("midrst.out_rd", 32'(rd_a), 32'd0);
        chk("midrst.out_imm", imm_a, 32'd0);
        chk("midrst.out_illegal", 32'(ill_a), 32'd0);
        rst = 1'b1; out_ready = 1'b1;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
